// File: rtl/id_ex_if.sv
// ID/EX pipeline bus.
// Carries the decoded instruction from ID, the flush request, the registered
// EX-side copy, the load-use stall and the bubble counter.
//   master : ID side, which drives id_* and flush and observes ex_*, stall, bubble_count
//   slave  : the id_ex_stage register itself
interface id_ex_if #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
);
  // ID side
  logic              id_valid;
  logic              id_RegDst, id_ALUSrc, id_MemtoReg, id_RegWrite;
  logic              id_MemRead, id_MemWrite, id_Branch, id_Jump;
  logic [3:0]        id_ALUOperation;
  logic [DATA_W-1:0] id_rd1, id_rd2, id_imm, id_pc;
  logic [REG_W-1:0]  id_rs, id_rt, id_rd;
  logic              flush;
  // EX side
  logic              ex_valid;
  logic              ex_RegDst, ex_ALUSrc, ex_MemtoReg, ex_RegWrite;
  logic              ex_MemRead, ex_MemWrite, ex_Branch, ex_Jump;
  logic [3:0]        ex_ALUOperation;
  logic [DATA_W-1:0] ex_rd1, ex_rd2, ex_imm, ex_pc;
  logic [REG_W-1:0]  ex_rs, ex_rt, ex_rd;
  logic              stall;
  logic [15:0]       bubble_count;

  modport master (
    output id_valid, id_RegDst, id_ALUSrc, id_MemtoReg, id_RegWrite,
           id_MemRead, id_MemWrite, id_Branch, id_Jump, id_ALUOperation,
           id_rd1, id_rd2, id_imm, id_pc, id_rs, id_rt, id_rd, flush,
    input  ex_valid, ex_RegDst, ex_ALUSrc, ex_MemtoReg, ex_RegWrite,
           ex_MemRead, ex_MemWrite, ex_Branch, ex_Jump, ex_ALUOperation,
           ex_rd1, ex_rd2, ex_imm, ex_pc, ex_rs, ex_rt, ex_rd,
           stall, bubble_count
  );

  modport slave (
    input  id_valid, id_RegDst, id_ALUSrc, id_MemtoReg, id_RegWrite,
           id_MemRead, id_MemWrite, id_Branch, id_Jump, id_ALUOperation,
           id_rd1, id_rd2, id_imm, id_pc, id_rs, id_rt, id_rd, flush,
    output ex_valid, ex_RegDst, ex_ALUSrc, ex_MemtoReg, ex_RegWrite,
           ex_MemRead, ex_MemWrite, ex_Branch, ex_Jump, ex_ALUOperation,
           ex_rd1, ex_rd2, ex_imm, ex_pc, ex_rs, ex_rt, ex_rd,
           stall, bubble_count
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection.
// Registers the decoded instruction into EX with one cycle of latency.
// Inserts a bubble on flush (branch/jump squash) or on a load-use hazard.
// Raises stall so PC and IF/ID hold, and counts hazard bubbles (saturating).
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : id_ex_if.slave -- id_* and flush in; ex_*, stall, bubble_count out
module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
) (
  input  logic   clk,
  input  logic   rst_n,
  id_ex_if.slave bus
);

  typedef struct packed {
    logic       RegDst;
    logic       ALUSrc;
    logic       MemtoReg;
    logic       RegWrite;
    logic       MemRead;
    logic       MemWrite;
    logic       Branch;
    logic       Jump;
    logic [3:0] ALUOperation;
  } ctrl_t;

  typedef struct packed {
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;
    logic [DATA_W-1:0] imm;
    logic [DATA_W-1:0] pc;
    logic [REG_W-1:0]  rs;
    logic [REG_W-1:0]  rt;
    logic [REG_W-1:0]  rd;
  } data_t;

  localparam ctrl_t CTRL_NOP = '0;

  ctrl_t       id_ctrl;
  data_t       id_data;
  ctrl_t       ctrl_d, ctrl_q;
  data_t       data_d, data_q;
  logic        valid_d, valid_q;
  logic [15:0] bubble_cnt_d, bubble_cnt_q;
  logic        rs_hit, rt_hit, rt_read;
  logic        hazard;
  logic        hz_bubble;

  // Gather ID inputs. RegDst/MemtoReg are don't-care for BEQ/SW and can arrive
  // as x from decode; the if/else maps anything but a clean 1 to 0 so x never
  // reaches EX.
  always_comb begin
    id_ctrl              = CTRL_NOP;
    id_ctrl.ALUSrc       = bus.id_ALUSrc;
    id_ctrl.RegWrite     = bus.id_RegWrite;
    id_ctrl.MemRead      = bus.id_MemRead;
    id_ctrl.MemWrite     = bus.id_MemWrite;
    id_ctrl.Branch       = bus.id_Branch;
    id_ctrl.Jump         = bus.id_Jump;
    id_ctrl.ALUOperation = bus.id_ALUOperation;
    if (bus.id_RegDst) id_ctrl.RegDst = 1'b1;
    else               id_ctrl.RegDst = 1'b0;
    if (bus.id_MemtoReg) id_ctrl.MemtoReg = 1'b1;
    else                 id_ctrl.MemtoReg = 1'b0;
  end

  always_comb begin
    id_data.rd1 = bus.id_rd1;
    id_data.rd2 = bus.id_rd2;
    id_data.imm = bus.id_imm;
    id_data.pc  = bus.id_pc;
    id_data.rs  = bus.id_rs;
    id_data.rt  = bus.id_rt;
    id_data.rd  = bus.id_rd;
  end

  // Load-use hazard: a load in EX writes ex_rt. The ID instruction always reads
  // rs; it reads rt only when rt is a source (register-form ALU op, or a store
  // whose rt is the data to write). Register 0 gets no exemption.
  always_comb begin
    rs_hit  = (data_q.rt == bus.id_rs);
    rt_hit  = (data_q.rt == bus.id_rt);
    rt_read = !bus.id_ALUSrc || bus.id_MemWrite;
    hazard  = valid_q && ctrl_q.MemRead && bus.id_valid &&
              (rs_hit || (rt_hit && rt_read));
  end

  // Flush wins over the hazard: the instruction is being squashed, so there is
  // nothing to hold back and the bubble is not counted as a hazard bubble.
  assign hz_bubble = hazard && !bus.flush;

  always_comb begin
    valid_d      = valid_q;
    ctrl_d       = ctrl_q;
    data_d       = data_q;
    bubble_cnt_d = bubble_cnt_q;
    if (bus.flush || hazard) begin
      // Bubble: controls cleared, data/index fields keep their last values.
      valid_d = 1'b0;
      ctrl_d  = CTRL_NOP;
      if (hz_bubble && (bubble_cnt_q != 16'hFFFF))
        bubble_cnt_d = bubble_cnt_q + 16'd1;
    end else begin
      valid_d = bus.id_valid;
      ctrl_d  = bus.id_valid ? id_ctrl : CTRL_NOP;
      data_d  = id_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q      <= 1'b0;
      ctrl_q       <= CTRL_NOP;
      data_q       <= '0;
      bubble_cnt_q <= '0;
    end else begin
      valid_q      <= valid_d;
      ctrl_q       <= ctrl_d;
      data_q       <= data_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign bus.stall           = hz_bubble;
  assign bus.bubble_count    = bubble_cnt_q;
  assign bus.ex_valid        = valid_q;
  assign bus.ex_RegDst       = ctrl_q.RegDst;
  assign bus.ex_ALUSrc       = ctrl_q.ALUSrc;
  assign bus.ex_MemtoReg     = ctrl_q.MemtoReg;
  assign bus.ex_RegWrite     = ctrl_q.RegWrite;
  assign bus.ex_MemRead      = ctrl_q.MemRead;
  assign bus.ex_MemWrite     = ctrl_q.MemWrite;
  assign bus.ex_Branch       = ctrl_q.Branch;
  assign bus.ex_Jump         = ctrl_q.Jump;
  assign bus.ex_ALUOperation = ctrl_q.ALUOperation;
  assign bus.ex_rd1          = data_q.rd1;
  assign bus.ex_rd2          = data_q.rd2;
  assign bus.ex_imm          = data_q.imm;
  assign bus.ex_pc           = data_q.pc;
  assign bus.ex_rs           = data_q.rs;
  assign bus.ex_rt           = data_q.rt;
  assign bus.ex_rd           = data_q.rd;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed instruction sequences, a behavioural model of
// the EX-side state checked on every falling edge, plus literal expectations.
module tb_id_ex_stage;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  id_ex_if #(.DATA_W(32), .REG_W(5)) bus ();

  id_ex_stage #(.DATA_W(32), .REG_W(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic        valid;
    logic        RegDst, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, Jump;
    logic [3:0]  alu;
    logic [31:0] rd1, rd2, imm, pc;
    logic [4:0]  rs, rt, rd;
  } ins_t;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- instruction builders ----------------
  function automatic ins_t nop();
    ins_t i;
    i = '{default: '0};
    return i;
  endfunction

  function automatic ins_t f_add(input logic [4:0] rs, rt, rd, input logic [31:0] a, b, pc);
    ins_t i = nop();
    i.valid = 1; i.RegDst = 1; i.RegWrite = 1; i.alu = 4'b0001;
    i.rs = rs; i.rt = rt; i.rd = rd; i.rd1 = a; i.rd2 = b; i.pc = pc;
    return i;
  endfunction

  function automatic ins_t f_lw(input logic [4:0] rs, rt, input logic [31:0] imm, pc);
    ins_t i = nop();
    i.valid = 1; i.ALUSrc = 1; i.MemtoReg = 1; i.RegWrite = 1; i.MemRead = 1;
    i.alu = 4'b0001; i.rs = rs; i.rt = rt; i.imm = imm; i.pc = pc;
    return i;
  endfunction

  function automatic ins_t f_addi(input logic [4:0] rs, rt, input logic [31:0] imm, pc);
    ins_t i = nop();
    i.valid = 1; i.ALUSrc = 1; i.RegWrite = 1; i.alu = 4'b0001;
    i.rs = rs; i.rt = rt; i.imm = imm; i.pc = pc;
    return i;
  endfunction

  function automatic ins_t f_sw(input logic [4:0] rs, rt, input logic [31:0] imm, pc);
    ins_t i = nop();
    i.valid = 1; i.ALUSrc = 1; i.MemWrite = 1; i.RegDst = 1'bx; i.MemtoReg = 1'bx;
    i.alu = 4'b0001; i.rs = rs; i.rt = rt; i.imm = imm; i.pc = pc;
    return i;
  endfunction

  function automatic ins_t f_beq(input logic [4:0] rs, rt, input logic [31:0] pc);
    ins_t i = nop();
    i.valid = 1; i.Branch = 1; i.RegDst = 1'bx; i.MemtoReg = 1'bx;
    i.alu = 4'b0010; i.rs = rs; i.rt = rt; i.pc = pc;
    return i;
  endfunction

  ins_t cur;

  task automatic put(input ins_t i, input logic fl);
    cur                 = i;
    bus.id_valid        = i.valid;
    bus.id_RegDst       = i.RegDst;
    bus.id_ALUSrc       = i.ALUSrc;
    bus.id_MemtoReg     = i.MemtoReg;
    bus.id_RegWrite     = i.RegWrite;
    bus.id_MemRead      = i.MemRead;
    bus.id_MemWrite     = i.MemWrite;
    bus.id_Branch       = i.Branch;
    bus.id_Jump         = i.Jump;
    bus.id_ALUOperation = i.alu;
    bus.id_rd1 = i.rd1; bus.id_rd2 = i.rd2; bus.id_imm = i.imm; bus.id_pc = i.pc;
    bus.id_rs  = i.rs;  bus.id_rt  = i.rt;  bus.id_rd  = i.rd;
    bus.flush  = fl;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // ---------------- behavioural model ----------------
  // m_ex is what EX holds; m_known says whether its data fields are defined
  // (they are don't-care after an invalid instruction was loaded).
  ins_t        m_ex = '{default: '0};
  logic        m_known = 1'b1;
  logic [15:0] m_cnt = '0;
  logic        preload_pulse = 1'b0;

  // The ID instruction needs the loaded value if the load's destination is one
  // of its source registers; rt is a source unless the immediate replaces it,
  // and a store always sources rt.
  function automatic logic m_hazard(input ins_t ex, input ins_t id);
    logic uses_rt;
    if (!(ex.valid && ex.MemRead && id.valid)) return 1'b0;
    uses_rt = !id.ALUSrc || id.MemWrite;
    return (id.rs == ex.rt) || (uses_rt && id.rt == ex.rt);
  endfunction

  always @(posedge clk or negedge rst_n or posedge preload_pulse) begin
    if (!rst_n) begin
      m_ex = '{default: '0};
      m_known = 1'b1;
      m_cnt = '0;
    end else if (preload_pulse) begin
      m_cnt = 16'hFFFE;
    end else begin
      logic hz;
      hz = m_hazard(m_ex, cur);
      if (bus.flush || hz) begin
        m_ex.valid = 0;
        m_ex.RegDst = 0; m_ex.ALUSrc = 0; m_ex.MemtoReg = 0; m_ex.RegWrite = 0;
        m_ex.MemRead = 0; m_ex.MemWrite = 0; m_ex.Branch = 0; m_ex.Jump = 0;
        m_ex.alu = 0;
        if (!bus.flush && m_cnt != 16'hFFFF) m_cnt = m_cnt + 1;
      end else begin
        m_ex = cur;
        m_ex.RegDst   = (cur.RegDst === 1'b1);
        m_ex.MemtoReg = (cur.MemtoReg === 1'b1);
        if (!cur.valid) begin
          m_ex.RegDst = 0; m_ex.ALUSrc = 0; m_ex.MemtoReg = 0; m_ex.RegWrite = 0;
          m_ex.MemRead = 0; m_ex.MemWrite = 0; m_ex.Branch = 0; m_ex.Jump = 0;
          m_ex.alu = 0;
        end
        m_known = cur.valid;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    chk("ex_valid", {63'd0, bus.ex_valid}, {63'd0, m_ex.valid});
    chk("ex_ctrl",
        {52'd0, bus.ex_RegDst, bus.ex_ALUSrc, bus.ex_MemtoReg, bus.ex_RegWrite,
         bus.ex_MemRead, bus.ex_MemWrite, bus.ex_Branch, bus.ex_Jump, bus.ex_ALUOperation},
        {52'd0, m_ex.RegDst, m_ex.ALUSrc, m_ex.MemtoReg, m_ex.RegWrite,
         m_ex.MemRead, m_ex.MemWrite, m_ex.Branch, m_ex.Jump, m_ex.alu});
    chk("bubble_count", {48'd0, bus.bubble_count}, {48'd0, m_cnt});
    chk("stall", {63'd0, bus.stall},
        {63'd0, rst_n && m_hazard(m_ex, cur) && !bus.flush});
    if (m_known) begin
      chk("ex_rd1_rd2", {bus.ex_rd1, bus.ex_rd2}, {m_ex.rd1, m_ex.rd2});
      chk("ex_imm_pc", {bus.ex_imm, bus.ex_pc}, {m_ex.imm, m_ex.pc});
      chk("ex_rs_rt_rd", {49'd0, bus.ex_rs, bus.ex_rt, bus.ex_rd},
          {49'd0, m_ex.rs, m_ex.rt, m_ex.rd});
    end
  end

  // ---------------- directed sequence ----------------
  initial begin
    put(nop(), 1'b0);
    #1;
    chk("reset ex_valid", {63'd0, bus.ex_valid}, 64'd0);
    chk("reset bubble_count", {48'd0, bus.bubble_count}, 64'd0);
    chk("reset stall", {63'd0, bus.stall}, 64'd0);
    #11 rst_n = 1'b1;
    tick();

    // ADD, no hazard
    put(f_add(5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 32'h100), 1'b0);
    #1 chk("add stall", {63'd0, bus.stall}, 64'd0);
    tick();
    chk("add ex_valid", {63'd0, bus.ex_valid}, 64'd1);
    chk("add ex_alu", {60'd0, bus.ex_ALUOperation}, 64'd1);
    chk("add ex_rd1", {32'd0, bus.ex_rd1}, 64'd5);
    chk("add ex_rd2", {32'd0, bus.ex_rd2}, 64'd7);
    chk("add stall after", {63'd0, bus.stall}, 64'd0);

    // LW rt=3 then ADD rs=3: one bubble
    put(f_lw(5'd1, 5'd3, 32'd8, 32'h104), 1'b0);
    tick();
    put(f_add(5'd3, 5'd5, 5'd6, 32'd11, 32'd12, 32'h108), 1'b0);
    #1 chk("lw-add stall", {63'd0, bus.stall}, 64'd1);
    tick();
    chk("lw-add bubble ctrl", {52'd0, bus.ex_RegWrite, bus.ex_MemRead, bus.ex_RegDst,
        bus.ex_ALUSrc, bus.ex_MemtoReg, bus.ex_MemWrite, bus.ex_Branch, bus.ex_Jump,
        bus.ex_ALUOperation}, 64'd0);
    chk("lw-add bubble held rt", {59'd0, bus.ex_rt}, 64'd3);
    chk("lw-add bubble_count", {48'd0, bus.bubble_count}, 64'd1);
    chk("lw-add stall cleared", {63'd0, bus.stall}, 64'd0);
    tick();
    chk("lw-add add enters", {62'd0, bus.ex_valid, bus.ex_RegWrite}, 64'd3);
    chk("lw-add add rs", {59'd0, bus.ex_rs}, 64'd3);

    // Register 0 is not exempt
    put(f_lw(5'd1, 5'd0, 32'd0, 32'h10C), 1'b0);
    tick();
    put(f_add(5'd0, 5'd7, 5'd8, 32'd1, 32'd2, 32'h110), 1'b0);
    #1 chk("r0 stall", {63'd0, bus.stall}, 64'd1);
    tick();
    tick();
    chk("r0 bubble_count", {48'd0, bus.bubble_count}, 64'd2);

    // LW rt=4 then ADDI rt=4 (rt is a destination): no stall
    put(f_lw(5'd1, 5'd4, 32'd4, 32'h114), 1'b0);
    tick();
    put(f_addi(5'd2, 5'd4, 32'd9, 32'h118), 1'b0);
    #1 chk("addi stall", {63'd0, bus.stall}, 64'd0);
    // Same slot as SW rt=4 (rt is store data): stall
    put(f_sw(5'd2, 5'd4, 32'd12, 32'h118), 1'b0);
    #1 chk("sw stall", {63'd0, bus.stall}, 64'd1);
    tick();
    chk("sw bubble_count", {48'd0, bus.bubble_count}, 64'd3);
    tick();
    chk("sw x-squash", {61'd0, bus.ex_MemWrite, bus.ex_RegDst, bus.ex_MemtoReg}, 64'd4);
    put(f_addi(5'd2, 5'd4, 32'd9, 32'h11C), 1'b0);
    tick();
    chk("addi loads", {62'd0, bus.ex_ALUSrc, bus.ex_RegWrite}, 64'd3);
    chk("addi imm", {32'd0, bus.ex_imm}, 64'd9);

    // Hazard and flush together: flush wins, not counted
    put(f_lw(5'd1, 5'd7, 32'd0, 32'h120), 1'b0);
    tick();
    put(f_add(5'd7, 5'd1, 5'd2, 32'd3, 32'd4, 32'h124), 1'b1);
    #1 chk("flush stall", {63'd0, bus.stall}, 64'd0);
    tick();
    chk("flush bubble", {62'd0, bus.ex_valid, bus.ex_RegWrite}, 64'd0);
    chk("flush bubble_count", {48'd0, bus.bubble_count}, 64'd3);

    // Invalid instruction with controls set: controls forced to 0
    begin
      ins_t i;
      i = f_lw(5'd9, 5'd10, 32'd1, 32'h128);
      i.valid = 1'b0;
      put(i, 1'b0);
    end
    tick();
    chk("invalid ctrl", {61'd0, bus.ex_valid, bus.ex_MemRead, bus.ex_RegWrite}, 64'd0);

    // BEQ with x on RegDst/MemtoReg
    put(f_beq(5'd1, 5'd2, 32'h12C), 1'b0);
    tick();
    chk("beq x-squash", {61'd0, bus.ex_Branch, bus.ex_RegDst, bus.ex_MemtoReg}, 64'd4);

    // Saturation: start the counter one short of the top, then two hazards
    force dut.bubble_cnt_q = 16'hFFFE;
    preload_pulse = 1'b1;
    #1;
    release dut.bubble_cnt_q;
    preload_pulse = 1'b0;
    for (int k = 0; k < 2; k++) begin
      put(f_lw(5'd1, 5'd5, 32'd0, 32'h130), 1'b0);
      tick();
      put(f_add(5'd5, 5'd5, 5'd6, 32'd1, 32'd1, 32'h134), 1'b0);
      tick();
      chk("sat bubble_count", {48'd0, bus.bubble_count}, 64'hFFFF);
      tick();
    end

    // Async reset between edges with a valid instruction in EX
    put(f_lw(5'd2, 5'd9, 32'h44, 32'h138), 1'b0);
    tick();
    chk("pre-reset ex_valid", {63'd0, bus.ex_valid}, 64'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("async rst ex_valid", {63'd0, bus.ex_valid}, 64'd0);
    chk("async rst ctrl", {62'd0, bus.ex_MemRead, bus.ex_RegWrite}, 64'd0);
    chk("async rst data", {bus.ex_imm, bus.ex_pc}, 64'd0);
    chk("async rst bubble_count", {48'd0, bus.bubble_count}, 64'd0);
    #2 rst_n = 1'b1;
    put(f_add(5'd9, 5'd3, 5'd4, 32'd21, 32'd22, 32'h13C), 1'b0);
    tick();
    chk("post-reset load", {63'd0, bus.ex_valid}, 64'd1);
    chk("post-reset rd1", {32'd0, bus.ex_rd1}, 64'd21);

    put(nop(), 1'b0);
    tick();
    tick();
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
